// File: rtl/risc_pkg.sv
// Shared fetch-path types: FSM state encoding, prefetch FIFO entry and the canonical NOP.
package risc_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StDrain,
    StHalt
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with synchronous flush; Depth must be a power of 2.
module fetch_fifo
  import risc_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fetch_entry_t               wdata_i,
  input  logic                       pop_i,
  output fetch_entry_t               rdata_o,
  output logic                       valid_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  // Flush wins over both push and pop in the same cycle.
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && (count_q != '0) && !flush_i;

  always_comb begin
    wptr_d  = do_push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = do_pop ? rptr_q + PtrW'(1) : rptr_q;
    count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests, buffers responses.
// Build option FETCH_MISALIGN_TRAP_EN: a misaligned redirect halts fetch and raises if_misalign_o.
module fetch_unit
  import risc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            if_valid_o,
  input  logic            if_ready_i,
  output logic [31:0]     if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic            if_misalign_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d, tgt_pc;
  logic [CntW-1:0] outst_q, outst_d, drop_q, drop_d, fifo_count;
  logic            gnt_fire, rsp_fire, redirect, misalign, push, fifo_valid;
  fetch_entry_t    fifo_head, push_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign tgt_pc        = redirect_pc_i;
  assign misalign      = redirect && (redirect_pc_i[1:0] != 2'b00);
  assign if_misalign_o = (state_q == StHalt);
`else
  assign tgt_pc        = redirect_pc_i & ~XLEN'(3);
  assign misalign      = 1'b0;
  assign if_misalign_o = 1'b0;
`endif

  assign redirect    = redirect_valid_i && (state_q != StHalt);
  assign imem_req_o  = (state_q == StRun) && ((32'(fifo_count) + 32'(outst_q)) < FIFO_DEPTH);
  assign imem_addr_o = pc_q;
  assign gnt_fire    = imem_req_o && imem_gnt_i;
  // Responses with nothing outstanding belong to requests issued before reset.
  assign rsp_fire    = imem_rvalid_i && (outst_q != '0);
  assign push        = rsp_fire && (drop_q == '0) && !redirect && (state_q != StHalt);
  assign push_entry  = '{pc: resp_pc_q, instr: imem_rdata_i};

  always_comb begin
    outst_d   = outst_q + CntW'(gnt_fire) - CntW'(rsp_fire);
    pc_d      = gnt_fire ? pc_q + XLEN'(4) : pc_q;
    resp_pc_d = push ? resp_pc_q + XLEN'(4) : resp_pc_q;
    drop_d    = (rsp_fire && (drop_q != '0)) ? drop_q - CntW'(1) : drop_q;
    state_d   = state_q;
    // Everything still in flight after this cycle is stale, including a same-cycle grant.
    if (redirect) begin
      pc_d      = tgt_pc;
      resp_pc_d = tgt_pc;
      drop_d    = outst_d;
    end
    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   if (redirect && (outst_d != '0)) state_d = StDrain;
      StDrain: if (drop_d == '0) state_d = StRun;
      default: state_d = state_q;
    endcase
    if (misalign) state_d = StHalt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StBoot;
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
    end
  end

  fetch_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .flush_i(redirect),
    .push_i (push),
    .wdata_i(push_entry),
    .pop_i  (if_ready_i),
    .rdata_o(fifo_head),
    .valid_o(fifo_valid),
    .count_o(fifo_count)
  );

  always_comb begin
    if_valid_o = fifo_valid;
    if_pc_o    = fifo_head.pc;
    if_instr_o = fifo_head.instr;
    if (state_q == StHalt) begin
      if_valid_o = 1'b1;
      if_pc_o    = pc_q;
      if_instr_o = INSTR_NOP;
    end else if (!fifo_valid) begin
      if_pc_o    = pc_q;
      if_instr_o = INSTR_NOP;
    end
  end

endmodule
